// File: rtl/gb_loader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gb_loader_pkg: shared constants and state types for the ROM loader   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package gb_loader_pkg;

  localparam logic [23:0] HDR_CSUM_FIRST = 24'h000134;
  localparam logic [23:0] HDR_CGB        = 24'h000143;
  localparam logic [23:0] HDR_CART       = 24'h000147;
  localparam logic [23:0] HDR_ROM        = 24'h000148;
  localparam logic [23:0] HDR_RAM        = 24'h000149;
  localparam logic [23:0] HDR_CSUM_LAST  = 24'h00014C;
  localparam logic [23:0] HDR_CSUM       = 24'h00014D;

  localparam logic [1:0] DS_WORD = 2'b11;
  localparam logic [1:0] DS_LO   = 2'b01;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_REQ  = 2'd1,
    WR_WAIT = 2'd2
  } wr_state_t;

  typedef enum logic [1:0] {
    LD_IDLE  = 2'd0,
    LD_LOAD  = 2'd1,
    LD_FLUSH = 2'd2
  } ld_state_t;

endpackage
`default_nettype wire

// File: rtl/loader_word_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | loader_word_fifo: synchronous FIFO of {addr, data, ds} write words   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module loader_word_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 41
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned c_AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW:0]    r_wr_ptr;
  logic [c_AW:0]    r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                 (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
  assign dout  = r_mem[r_rd_ptr[c_AW-1:0]];

  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !clear) r_mem[r_wr_ptr[c_AW-1:0]] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/gb_rom_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gb_rom_loader: packs the iosys ROM byte stream into SDRAM words and  |
// | captures/validates the GB cartridge header.  Revision: 1.0           |
// +----------------------------------------------------------------------+
module gb_rom_loader
  import gb_loader_pkg::*;
#(
  parameter logic [22:0] BASE_ADDR  = 23'h000000,
  parameter int unsigned MAX_BYTES  = 8388608,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        rom_loading,
  input  logic [7:0]  rom_do,
  input  logic        rom_do_valid,
  output logic        mem_req,
  output logic [22:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic [1:0]  mem_ds,
  input  logic        mem_ack,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic [22:0] rom_bytes,
  output logic [7:0]  cart_type,
  output logic [7:0]  rom_size,
  output logic [7:0]  ram_size,
  output logic [7:0]  cgb_flag,
  output logic        hdr_ok
);

  localparam int unsigned c_FW = 41;

  logic            r_loading_d, r_valid_d;
  logic [23:0]     r_cnt;
  logic [7:0]      r_lo, r_csum;
  ld_state_t       r_ld_state, w_ld_next;
  wr_state_t       r_wr_state, w_wr_next;
  logic            r_stale;
  logic            w_start, w_end, w_byte, w_room, w_accept;
  logic            w_push, w_push_tail, w_pop, w_latch, w_flush_done;
  logic [22:0]     w_push_addr;
  logic [c_FW-1:0] w_push_word, w_head;
  logic            w_full, w_empty;

  assign w_start  = rom_loading & ~r_loading_d;
  assign w_end    = ~rom_loading & r_loading_d;
  assign w_byte   = rom_do_valid & ~r_valid_d & rom_loading & r_loading_d;
  assign w_room   = (r_cnt != 24'(MAX_BYTES));
  assign w_accept = w_byte & w_room;

  assign w_push_tail = w_end & r_cnt[0] & (r_ld_state == LD_LOAD);
  assign w_push      = (w_accept & r_cnt[0]) | w_push_tail;
  // Odd offset (or odd tail) always lands on the even address just below
  assign w_push_addr = BASE_ADDR + r_cnt[22:0] - 23'd1;
  assign w_push_word = w_push_tail ? {w_push_addr, 8'h00, r_lo, DS_LO}
                                   : {w_push_addr, rom_do, r_lo, DS_WORD};

  loader_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (c_FW)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .clear  (w_start),
    .push   (w_push),
    .din    (w_push_word),
    .pop    (w_pop),
    .dout   (w_head),
    .full   (w_full),
    .empty  (w_empty)
  );

  assign rom_bytes = r_cnt[22:0];
  assign busy      = (r_ld_state != LD_IDLE);
  assign mem_req   = (r_wr_state == WR_REQ);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_loading_d <= 1'b0;
      r_valid_d   <= 1'b0;
      r_cnt       <= '0;
      r_lo        <= '0;
      r_csum      <= '0;
      cart_type   <= '0;
      rom_size    <= '0;
      ram_size    <= '0;
      cgb_flag    <= '0;
      hdr_ok      <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      r_loading_d <= rom_loading;
      r_valid_d   <= rom_do_valid;
      if (w_start) begin
        r_cnt     <= '0;
        r_lo      <= '0;
        r_csum    <= '0;
        cart_type <= '0;
        rom_size  <= '0;
        ram_size  <= '0;
        cgb_flag  <= '0;
        hdr_ok    <= 1'b0;
        overflow  <= 1'b0;
      end else begin
        if (w_accept) begin
          r_cnt <= r_cnt + 24'd1;
          if (!r_cnt[0]) r_lo <= rom_do;
          if (r_cnt == HDR_CGB)  cgb_flag  <= rom_do;
          if (r_cnt == HDR_CART) cart_type <= rom_do;
          if (r_cnt == HDR_ROM)  rom_size  <= rom_do;
          if (r_cnt == HDR_RAM)  ram_size  <= rom_do;
          if (r_cnt >= HDR_CSUM_FIRST && r_cnt <= HDR_CSUM_LAST)
            r_csum <= r_csum - rom_do - 8'd1;
          if (r_cnt == HDR_CSUM) hdr_ok <= (rom_do == r_csum);
        end
        if ((w_byte && !w_room) || (w_push && w_full && !w_pop))
          overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ld_state <= LD_IDLE;
      done       <= 1'b0;
    end else begin
      r_ld_state <= w_ld_next;
      if (w_start)           done <= 1'b0;
      else if (w_flush_done) done <= 1'b1;
    end
  end

  always_comb begin
    w_ld_next    = r_ld_state;
    w_flush_done = 1'b0;
    if (w_start) begin
      w_ld_next = LD_LOAD;
    end else begin
      case (r_ld_state)
        LD_LOAD:  if (w_end) w_ld_next = LD_FLUSH;
        LD_FLUSH: if (w_empty && r_wr_state == WR_IDLE) begin
          w_ld_next    = LD_IDLE;
          w_flush_done = 1'b1;
        end
        default:  w_ld_next = r_ld_state;
      endcase
    end
  end

  // A request in flight across a new load start no longer owns the FIFO head
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_state <= WR_IDLE;
      r_stale    <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_ds     <= '0;
    end else begin
      r_wr_state <= w_wr_next;
      if (w_latch) begin
        r_stale                       <= 1'b0;
        {mem_addr, mem_wdata, mem_ds} <= w_head;
      end else if (w_start) begin
        r_stale <= 1'b1;
      end
    end
  end

  always_comb begin
    w_wr_next = r_wr_state;
    w_pop     = 1'b0;
    w_latch   = 1'b0;
    case (r_wr_state)
      WR_IDLE: if (!w_empty && !w_start) begin
        w_wr_next = WR_REQ;
        w_latch   = 1'b1;
      end
      WR_REQ: if (mem_ack) begin
        w_wr_next = WR_WAIT;
        w_pop     = ~r_stale;
      end
      WR_WAIT: w_wr_next = WR_IDLE;
      default: w_wr_next = WR_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_gb_rom_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_gb_rom_loader: directed self-checking bench for gb_rom_loader     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_gb_rom_loader;

  logic        clk, resetn, rom_loading, rom_do_valid;
  logic [7:0]  rom_do;
  logic        mem_req, mem_ack, busy, done, overflow, hdr_ok;
  logic [22:0] mem_addr, rom_bytes;
  logic [15:0] mem_wdata;
  logic [1:0]  mem_ds;
  logic [7:0]  cart_type, rom_size, ram_size, cgb_flag;

  logic        mem_req8, mem_ack8, busy8, done8, overflow8, hdr_ok8;
  logic [22:0] mem_addr8, rom_bytes8;
  logic [15:0] mem_wdata8;
  logic [1:0]  mem_ds8;
  logic [7:0]  cart_type8, rom_size8, ram_size8, cgb_flag8;

  int checks = 0;
  int failures = 0;

  logic [22:0] q_addr[$];
  logic [15:0] q_data[$];
  logic [1:0]  q_ds[$];
  int          writes8;
  logic [22:0] last_addr8;
  logic [15:0] last_data8;
  int          ack_delay = 2;
  logic        ack_block = 1'b0;
  logic [7:0]  img [0:511];

  gb_rom_loader u_dut (
    .clk(clk), .resetn(resetn), .rom_loading(rom_loading), .rom_do(rom_do),
    .rom_do_valid(rom_do_valid), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ds(mem_ds), .mem_ack(mem_ack), .busy(busy),
    .done(done), .overflow(overflow), .rom_bytes(rom_bytes), .cart_type(cart_type),
    .rom_size(rom_size), .ram_size(ram_size), .cgb_flag(cgb_flag), .hdr_ok(hdr_ok)
  );

  gb_rom_loader #(.MAX_BYTES(8)) u_dut8 (
    .clk(clk), .resetn(resetn), .rom_loading(rom_loading), .rom_do(rom_do),
    .rom_do_valid(rom_do_valid), .mem_req(mem_req8), .mem_addr(mem_addr8),
    .mem_wdata(mem_wdata8), .mem_ds(mem_ds8), .mem_ack(mem_ack8), .busy(busy8),
    .done(done8), .overflow(overflow8), .rom_bytes(rom_bytes8), .cart_type(cart_type8),
    .rom_size(rom_size8), .ram_size(ram_size8), .cgb_flag(cgb_flag8), .hdr_ok(hdr_ok8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // SDRAM responders: main DUT acks after ack_delay cycles, small DUT at once
  initial begin
    int req_cnt;
    req_cnt  = 0;
    mem_ack  = 1'b0;
    mem_ack8 = 1'b0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (mem_req && !ack_block) begin
        if (req_cnt == ack_delay) begin
          mem_ack = 1'b1;
          req_cnt = 0;
          q_addr.push_back(mem_addr);
          q_data.push_back(mem_wdata);
          q_ds.push_back(mem_ds);
        end else begin
          req_cnt++;
        end
      end else begin
        req_cnt = 0;
      end
      if (mem_req8 && !mem_ack8) begin
        mem_ack8   = 1'b1;
        writes8++;
        last_addr8 = mem_addr8;
        last_data8 = mem_wdata8;
      end else begin
        mem_ack8 = 1'b0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    rom_do       = b;
    rom_do_valid = 1'b1;
    repeat (2) @(negedge clk);
    rom_do_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic start_load();
    q_addr.delete();
    q_data.delete();
    q_ds.delete();
    writes8     = 0;
    rom_loading = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic end_load();
    int t;
    t = 0;
    @(negedge clk);
    rom_loading = 1'b0;
    @(negedge clk);
    while (!done && t < 3000) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL load_done: done=%b busy=%b required done=1 busy=0", done, busy);
    end
  endtask

  task automatic run_load(input int n);
    start_load();
    for (int i = 0; i < n; i++) send_byte(img[i]);
    end_load();
  endtask

  task automatic check_write(input int idx, input logic [22:0] a,
                             input logic [15:0] d, input logic [1:0] s);
    checks++;
    if (idx >= q_addr.size()) begin
      failures++;
      $display("FAIL write%0d: missing, only %0d writes seen", idx, q_addr.size());
    end else if (q_addr[idx] !== a || q_data[idx] !== d || q_ds[idx] !== s) begin
      failures++;
      $display("FAIL write%0d: got addr=%h data=%h ds=%b required addr=%h data=%h ds=%b",
               idx, q_addr[idx], q_data[idx], q_ds[idx], a, d, s);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    rom_loading = 1'b0;
    rom_do_valid = 1'b0;
    rom_do = 8'h00;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({mem_req, mem_addr, mem_wdata, mem_ds, busy, done, overflow, rom_bytes,
         cart_type, rom_size, ram_size, cgb_flag, hdr_ok} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: req=%b busy=%b done=%b ovf=%b bytes=%h required all 0",
               mem_req, busy, done, overflow, rom_bytes);
    end
  endtask

  task automatic test_basic_words();
    img[0] = 8'h11; img[1] = 8'h22; img[2] = 8'h33; img[3] = 8'h44;
    run_load(4);
    checks++;
    if (q_addr.size() != 2 || rom_bytes !== 23'd4 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL basic_count: writes=%0d bytes=%0d ovf=%b required 2 4 0",
               q_addr.size(), rom_bytes, overflow);
    end
    check_write(0, 23'h000000, 16'h2211, 2'b11);
    check_write(1, 23'h000002, 16'h4433, 2'b11);
  endtask

  task automatic test_odd_tail();
    img[0] = 8'hAA; img[1] = 8'hBB; img[2] = 8'hCC;
    run_load(3);
    checks++;
    if (q_addr.size() != 2 || rom_bytes !== 23'd3 || hdr_ok !== 1'b0) begin
      failures++;
      $display("FAIL odd_count: writes=%0d bytes=%0d hdr_ok=%b required 2 3 0",
               q_addr.size(), rom_bytes, hdr_ok);
    end
    check_write(0, 23'h000000, 16'hBBAA, 2'b11);
    check_write(1, 23'h000002, 16'h00CC, 2'b01);
  endtask

  task automatic test_header();
    logic [7:0] x;
    for (int i = 0; i < 'h150; i++) img[i] = 8'(i * 7 + 3);
    img['h143] = 8'h80; img['h147] = 8'h13; img['h148] = 8'h05; img['h149] = 8'h03;
    x = 8'h00;
    for (int i = 'h134; i <= 'h14C; i++) x = x - img[i] - 8'd1;
    img['h14D] = x;
    run_load('h150);
    checks++;
    if (cgb_flag !== 8'h80 || cart_type !== 8'h13 || rom_size !== 8'h05 ||
        ram_size !== 8'h03 || hdr_ok !== 1'b1) begin
      failures++;
      $display("FAIL header_good: cgb=%h cart=%h rom=%h ram=%h ok=%b required 80 13 05 03 1",
               cgb_flag, cart_type, rom_size, ram_size, hdr_ok);
    end
    checks++;
    if (q_addr.size() != 'hA8 || rom_bytes !== 23'h150 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL header_len: writes=%0d bytes=%h ovf=%b required 168 150 0",
               q_addr.size(), rom_bytes, overflow);
    end
    check_write('hA6, 23'h00014C, {img['h14D], img['h14C]}, 2'b11);
    img['h14D] = x ^ 8'hFF;
    run_load('h150);
    checks++;
    if (hdr_ok !== 1'b0 || cart_type !== 8'h13) begin
      failures++;
      $display("FAIL header_bad: ok=%b cart=%h required 0 13", hdr_ok, cart_type);
    end
  endtask

  task automatic test_fifo_full();
    ack_block = 1'b1;
    start_load();
    for (int i = 0; i < 12; i++) send_byte(8'(8'h10 + i));
    repeat (12) @(negedge clk);
    checks++;
    if (overflow !== 1'b1 || q_addr.size() != 0) begin
      failures++;
      $display("FAIL fifo_stall: ovf=%b writes=%0d required 1 0", overflow, q_addr.size());
    end
    ack_block = 1'b0;
    end_load();
    checks++;
    if (q_addr.size() != 4 || rom_bytes !== 23'd12 || overflow !== 1'b1) begin
      failures++;
      $display("FAIL fifo_count: writes=%0d bytes=%0d ovf=%b required 4 12 1",
               q_addr.size(), rom_bytes, overflow);
    end
    check_write(0, 23'h000000, 16'h1110, 2'b11);
    check_write(3, 23'h000006, 16'h1716, 2'b11);
  endtask

  task automatic test_async_reset();
    int t;
    ack_block = 1'b1;
    start_load();
    send_byte(8'h55);
    send_byte(8'h66);
    t = 0;
    while (!mem_req && t < 50) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (mem_req !== 1'b1) begin
      failures++;
      $display("FAIL areset_req: mem_req=%b required 1 before reset", mem_req);
    end
    #2 resetn = 1'b0;
    #1;
    checks++;
    if ({mem_req, mem_addr, mem_wdata, mem_ds, busy, done, overflow, rom_bytes,
         cart_type, rom_size, ram_size, cgb_flag, hdr_ok} !== '0) begin
      failures++;
      $display("FAIL areset_outputs: req=%b data=%h busy=%b bytes=%h required all 0",
               mem_req, mem_wdata, busy, rom_bytes);
    end
    @(negedge clk);
    rom_loading = 1'b0;
    ack_block = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    img[0] = 8'h01; img[1] = 8'h02;
    run_load(2);
    checks++;
    if (q_addr.size() != 1) begin
      failures++;
      $display("FAIL areset_reload: writes=%0d required 1", q_addr.size());
    end
    check_write(0, 23'h000000, 16'h0201, 2'b11);
  endtask

  task automatic test_max_bytes();
    for (int i = 0; i < 10; i++) img[i] = 8'(8'h60 + i);
    run_load(10);
    checks++;
    if (writes8 != 4 || last_addr8 !== 23'd6 || last_data8 !== 16'h6766) begin
      failures++;
      $display("FAIL max_writes: writes=%0d last_addr=%h last_data=%h required 4 000006 6766",
               writes8, last_addr8, last_data8);
    end
    checks++;
    if (rom_bytes8 !== 23'd8 || overflow8 !== 1'b1 || done8 !== 1'b1) begin
      failures++;
      $display("FAIL max_state: bytes=%0d ovf=%b done=%b required 8 1 1",
               rom_bytes8, overflow8, done8);
    end
    checks++;
    if (rom_bytes !== 23'd10 || q_addr.size() != 5 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL max_big: bytes=%0d writes=%0d ovf=%b required 10 5 0",
               rom_bytes, q_addr.size(), overflow);
    end
  endtask

  task automatic test_empty_load();
    run_load(0);
    checks++;
    if (rom_bytes !== 23'd0 || q_addr.size() != 0 || done !== 1'b1) begin
      failures++;
      $display("FAIL empty_load: bytes=%0d writes=%0d done=%b required 0 0 1",
               rom_bytes, q_addr.size(), done);
    end
  endtask

  initial begin
    test_reset();
    test_basic_words();
    test_odd_tail();
    test_header();
    test_fifo_full();
    test_async_reset();
    test_max_bytes();
    test_empty_load();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
